// File: rtl/board_byte_scanner.sv
// board_byte_scanner: presents the 64-bit CPU output word on the 8-bit board
// output one byte at a time. In auto mode it steps through bytes 0..7 with a
// programmable dwell and pulses frame_done on each 7->0 wrap. In manual mode
// the byte index follows sel_in.
// Optional feature: define SCANNER_SNAPSHOT_EN to build a 64-bit snapshot
// register loaded by capture. When it is defined, the scanner displays the
// snapshot instead of the live cpu_out word.
module board_byte_scanner #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cpu_out,
  input  logic        manual,
  input  logic [2:0]  sel_in,
  input  logic        hold,
  input  logic        capture,
  output logic [7:0]  out_to_board,
  output logic [2:0]  byte_idx,
  output logic        frame_done
);

  typedef enum logic {SCAN, MANUAL} state_t;

  localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_q, frame_d;
  logic [7:0]    out_q, out_d;
  logic [63:0]   src;

`ifdef SCANNER_SNAPSHOT_EN
  logic [63:0] snap_q;

  // Snapshot register: holds the word being displayed until the next capture.
  always_ff @(posedge clk) begin
    if (rst) snap_q <= '0;
    else if (capture) snap_q <= cpu_out;
  end

  assign src = snap_q;
`else
  logic capture_unused;

  assign capture_unused = capture;
  assign src            = cpu_out;
`endif

  // Next-state logic. Precedence is mode change > hold > counting, so a mode
  // change that lands on a terminal count suppresses both the step and the
  // frame pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    out_d   = src[{idx_q, 3'b000} +: 8];
    unique case (state_q)
      SCAN: begin
        if (manual) begin
          state_d = MANUAL;
          idx_d   = sel_in;
          cnt_d   = '0;
        end else if (!hold) begin
          if (cnt_q == TERM) begin
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            frame_d = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MANUAL: begin
        cnt_d = '0;
        if (manual) begin
          idx_d = sel_in;
        end else begin
          // Resume auto scan from the current index with a full dwell.
          state_d = SCAN;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      out_q   <= out_d;
    end
  end

  assign out_to_board = out_q;
  assign byte_idx     = idx_q;
  assign frame_done   = frame_q;

endmodule

// File: tb/tb_board_byte_scanner.sv
// Self-checking bench for board_byte_scanner with DWELL=4.
module tb_board_byte_scanner;

  localparam int unsigned DW = 4;
`ifdef SCANNER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cpu_out;
  logic        manual;
  logic [2:0]  sel_in;
  logic        hold;
  logic        capture;
  logic [7:0]  out_to_board;
  logic [2:0]  byte_idx;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] ob;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       manual;
    logic [2:0] sel;
    logic       hold;
    logic [2:0] exp_idx;
    logic [7:0] exp_ob;
    logic       exp_fd;
  } vec_t;

  vec_t tbl[25];

  board_byte_scanner #(.DWELL(DW), .CW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_out      (cpu_out),
    .manual       (manual),
    .sel_in       (sel_in),
    .hold         (hold),
    .capture      (capture),
    .out_to_board (out_to_board),
    .byte_idx     (byte_idx),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic edge_check(input string tag, input int n, input logic [2:0] idx,
                            input logic [7:0] ob, input logic fd);
    exp_t e;
    e.idx = idx;
    e.ob  = ob;
    e.fd  = fd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty", tag, n);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s[%0d].byte_idx", tag, n), 64'(byte_idx), 64'(e.idx));
      chk($sformatf("%s[%0d].out_to_board", tag, n), 64'(out_to_board), 64'(e.ob));
      chk($sformatf("%s[%0d].frame_done", tag, n), 64'(frame_done), 64'(e.fd));
    end
  endtask

  initial begin
    // Manual, return-to-scan, collision and wrap sequence (cpu_out = 8877665544332211).
    tbl[0]  = '{1'b1, 3'd6, 1'b0, 3'd6, 8'h55, 1'b0};
    tbl[1]  = '{1'b1, 3'd0, 1'b0, 3'd0, 8'h77, 1'b0};
    tbl[2]  = '{1'b1, 3'd7, 1'b1, 3'd7, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 1'b0, 3'd2, 8'h88, 1'b0};
    tbl[4]  = '{1'b1, 3'd2, 1'b0, 3'd2, 8'h33, 1'b0};
    tbl[5]  = '{1'b1, 3'd5, 1'b0, 3'd5, 8'h33, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 1'b1, 3'd5, 8'h66, 1'b0};
    tbl[7]  = '{1'b0, 3'd1, 1'b0, 3'd5, 8'h66, 1'b0};
    tbl[8]  = '{1'b0, 3'd1, 1'b0, 3'd5, 8'h66, 1'b0};
    tbl[9]  = '{1'b0, 3'd1, 1'b0, 3'd5, 8'h66, 1'b0};
    tbl[10] = '{1'b0, 3'd1, 1'b0, 3'd6, 8'h66, 1'b0};
    tbl[11] = '{1'b0, 3'd1, 1'b0, 3'd6, 8'h77, 1'b0};
    tbl[12] = '{1'b0, 3'd1, 1'b0, 3'd6, 8'h77, 1'b0};
    tbl[13] = '{1'b0, 3'd1, 1'b0, 3'd6, 8'h77, 1'b0};
    tbl[14] = '{1'b0, 3'd1, 1'b0, 3'd7, 8'h77, 1'b0};
    tbl[15] = '{1'b0, 3'd1, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[16] = '{1'b0, 3'd1, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[17] = '{1'b0, 3'd1, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[18] = '{1'b1, 3'd7, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[19] = '{1'b0, 3'd3, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[20] = '{1'b0, 3'd3, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[21] = '{1'b0, 3'd3, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[22] = '{1'b0, 3'd3, 1'b0, 3'd7, 8'h88, 1'b0};
    tbl[23] = '{1'b0, 3'd3, 1'b0, 3'd0, 8'h88, 1'b1};
    tbl[24] = '{1'b0, 3'd3, 1'b0, 3'd0, 8'h11, 1'b0};

    rst     = 1'b1;
    manual  = 1'b0;
    hold    = 1'b0;
    capture = 1'b1;
    sel_in  = 3'd0;
    cpu_out = 64'h8877665544332211;

    // Reset values.
    edge_check("reset", 0, 3'd0, 8'h00, 1'b0);
    edge_check("reset", 1, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // Auto scan: first step on the 4th edge, full frame wrap at edge 32.
    for (int n = 1; n <= 45; n++) begin
      logic [7:0] ob;
      ob = 8'(8'h11 * (((n - 1) / 4) % 8 + 1));
      if (n == 1 && SNAP) ob = 8'h00;
      edge_check("scan", n, 3'((n / 4) % 8), ob, (n % 32) == 0);
    end

    // Hold at index 3 with the count frozen at 1.
    hold = 1'b1;
    for (int n = 0; n < 10; n++) edge_check("hold", n, 3'd3, 8'h44, 1'b0);
    hold = 1'b0;
    edge_check("resume", 0, 3'd3, 8'h44, 1'b0);
    edge_check("resume", 1, 3'd3, 8'h44, 1'b0);
    edge_check("resume", 2, 3'd4, 8'h44, 1'b0);

    // Manual mode, return to scan, mode-change collision at terminal count.
    for (int i = 0; i < 25; i++) begin
      manual = tbl[i].manual;
      sel_in = tbl[i].sel;
      hold   = tbl[i].hold;
      edge_check("vec", i, tbl[i].exp_idx, tbl[i].exp_ob, tbl[i].exp_fd);
    end

    // Reset mid-scan wins over manual, hold and capture.
    rst     = 1'b1;
    manual  = 1'b1;
    hold    = 1'b1;
    capture = 1'b1;
    cpu_out = '1;
    edge_check("midrst", 0, 3'd0, 8'h00, 1'b0);

    // Snapshot: capture a word, then zero the live bus.
    rst     = 1'b0;
    manual  = 1'b0;
    hold    = 1'b0;
    cpu_out = 64'hA1A2A3A4A5A6A7A8;
    edge_check("snap", 1, 3'd0, SNAP ? 8'h00 : 8'hA8, 1'b0);
    capture = 1'b0;
    cpu_out = '0;
    for (int n = 2; n <= 33; n++) begin
      logic [7:0] ob;
      ob = SNAP ? 8'(8'hA8 - ((n - 1) / 4) % 8) : 8'h00;
      edge_check("snap", n, 3'((n / 4) % 8), ob, n == 32);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
